// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned REGFILE_DATA_W = 32;
  localparam int unsigned REGFILE_ADDR_W = 5;

  typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One read port: storage mux with write-first bypass and busy lookup.
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W = REGFILE_DATA_W,
  parameter int unsigned ADDR_W = REGFILE_ADDR_W,
  localparam int unsigned DEPTH = 1 << ADDR_W
) (
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic [DEPTH-1:0]  busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);

  logic hit;

  // A same-cycle write both supplies the data and retires the pending flag.
  always_comb begin
    hit   = we && (waddr == raddr);
    rdata = hit ? wdata : mem[raddr];
    rbusy = busy[raddr] & ~hit;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass and pending-write scoreboard.
// Define REGFILE_SB_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W = REGFILE_DATA_W,
  parameter int unsigned ADDR_W = REGFILE_ADDR_W,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     iss,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef REGFILE_SB_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   pend_cnt_q;
  logic [ADDR_W:0]   pend_cnt_d;
  logic              we_eff;
  logic              iss_eff;

  // With the zero register enabled, address 0 swallows writes and issues.
  always_comb begin
    we_eff  = we  & ~(ZERO_REG & (waddr    == '0));
    iss_eff = iss & ~(ZERO_REG & (iss_addr == '0));
  end

  // Issue is applied after the write so a same-address issue leaves busy set.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (we_eff) begin
      mem_d[waddr]  = wdata;
      busy_d[waddr] = 1'b0;
    end
    if (iss_eff) begin
      busy_d[iss_addr] = 1'b1;
    end
  end

  always_comb begin
    pend_cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pend_cnt_d = pend_cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .mem   (mem_q),
      .busy  (busy_q),
      .we    (we_eff),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr[k*ADDR_W +: ADDR_W]),
      .rdata (rdata[k*DATA_W +: DATA_W]),
      .rbusy (rbusy[k])
    );
  end

endmodule
